tfsm_xst_logger: RTL and testbench
==================================

Name: tfsm_xst_logger

Overview:
- Downstream consumer of the latch-based state register (cst/xst pair) in the tfsm library.
- Samples the current state cst and the transition-pending flag xst in the clk domain.
- Detects each settled state change and timestamps it.
- Queues change records {from, to, timestamp} in a small first-word-fall-through FIFO behind a valid/ready output, with overflow accounting. Used for trace/debug of transition FSMs.

Parameters:
- STMSB, 3, MSB index of the state vector (state width STMSB+1).
- ST0, all-zeros, reset state; must equal the upstream state register's ST0.
- SYNC, 2, synchronizer stages on xst and cst (0..3; 0 = direct sampling).
- TSW, 16, timestamp counter width.
- DEPTH, 4, FIFO entries (power of two, >= 2).

Ports:
- clk, input, 1, sole clock, rising edge.
- rstn, input, 1, asynchronous active-low reset.
- xst, input, 1, transition pending from upstream state register (1 = unsettled).
- cst, input, STMSB+1, current state from upstream state register.
- clr, input, 1, synchronous pulse: clears ovf and drop_cnt.
- o_valid, output, 1, head record available.
- o_ready, input, 1, consumer accepts head.
- o_from, output, STMSB+1, previous state of head record.
- o_to, output, STMSB+1, new state of head record.
- o_ts, output, TSW, timestamp of head record.
- level, output, $clog2(DEPTH)+1, FIFO occupancy.
- ovf, output, 1, sticky: at least one record dropped.
- drop_cnt, output, 8, saturating count of dropped records.

Behaviour:
- Reset (rstn=0, async): sync flops cleared to xst=0 and cst=ST0; last_st=ST0; ts=0; FIFO empty; o_valid=0; level=0; ovf=0; drop_cnt=0. o_from/o_to/o_ts are don't-care while o_valid=0; the bench must not check them.
- Reset mid-operation: all queued records are lost; no partial record is emitted after rstn rises.
- Synchronizer: xst_s and cst_s are the SYNC-stage registered copies; with SYNC=0 they are the raw inputs.
- Timestamp ts: free-running, +1 every clk edge, wraps 2^TSW-1 -> 0 with no flag.
- Event when xst_s==0 and cst_s!=last_st.
  - No event while xst_s==1. Intermediate values are ignored.
  - Only the settled value is logged once xst_s falls.
- On event, at the clk edge:
  - record {from=last_st, to=cst_s, ts=ts pre-increment} is pushed;
  - last_st <= cst_s.
- Latency: a cst change settled with xst low before edge k gives o_valid=1 after edge k+SYNC.
- Return to a previous state is a new event (A->B->A gives two records).
- FIFO is first-word fall-through: o_valid = level!=0, and head fields are valid in the same cycle.
  - Pop on o_valid && o_ready.
  - o_from/o_to/o_ts are held stable while o_valid && !o_ready.
- Full (level==DEPTH):
  - Push with simultaneous pop is accepted; level stays DEPTH.
  - Push without pop drops the record. last_st is still updated, ovf <= 1, drop_cnt += 1, saturating at 255.
- clr: ovf <= 0, drop_cnt <= 0.
  - clr coinciding with a drop: ovf=1, drop_cnt=1.
  - clr does not affect FIFO contents or ts.
- Empty with o_ready=1: no pop, level stays 0.
- Push and pop on the same cycle while not empty and not full: level unchanged, order preserved.
- Pointers wrap modulo DEPTH; pointers carry an extra MSB to distinguish full from empty.

Decomposition:
- Shared tfsm package: state width macro/constant, ST0 default, record field order {from,to,ts}.
- One sub-module: tfsm_fifo_fwft (parametric width/DEPTH, FWFT, push/pop/level/full/empty).
- Synchronizer, event detect, ts counter and overflow logic stay in the top module.

Test Plan:
- Reset then idle with cst=0, xst=0 for 20 cycles -> o_valid stays 0, level=0, ovf=0.
- SYNC=2, cst 0->5 with xst low, settled before edge k, ts=100 at edge k+2, o_ready=1 -> o_valid high after edge k+2 with {from=0,to=5,ts=100}, then level returns to 0.
- xst=1 while cst steps 5->3->7, then xst=0 -> exactly one record {5,7}; no record carries 3.
- o_ready=0, DEPTH=4, six changes 1,2,3,4,5,6 -> level=4, ovf=1, drop_cnt=2. Draining yields to=1,2,3,4. The next change to 7 yields from=6.
- Full FIFO, push coincident with pop -> level stays 4, no drop. Then clr in the same cycle as a drop -> ovf=1, drop_cnt=1.
- ts wrap with TSW=4: event at ts=15, next at ts=0 -> o_ts=15 then 0. Assert rstn low mid-queue -> o_valid=0 immediately, level=0.

Source files
------------

// File: rtl/tfsm_xst_logger_pkg.sv
// Shared tfsm definitions: default state/timestamp widths, record layout and
// the saturating drop counter helper used by the transition logger.
package tfsm_xst_logger_pkg;

  localparam int TFSM_STMSB = 3;
  localparam int TFSM_TSW   = 16;
  localparam int DROP_W     = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;

  // Records are packed as {from, to, ts}, from in the MSBs.
  function automatic int rec_width(input int stmsb, input int tsw);
    return 2 * (stmsb + 1) + tsw;
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tfsm_xst_logger_fifo.sv
// First-word-fall-through FIFO: head word is visible whenever not empty.
// Pointers carry one extra MSB so full and empty can be told apart.
module tfsm_fifo_fwft #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic         wr_s;
  logic         rd_s;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_s    = pop_i && !empty_o;
  // A push into a full FIFO is only accepted when a pop frees the head slot.
  assign wr_s    = push_i && (!full_o || rd_s);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_s) begin
        wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (rd_s) begin
        rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents are don't-care until pointed at by a valid head.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/tfsm_xst_logger.sv
// Logs each settled state change of an upstream cst/xst state register as a
// timestamped {from, to, ts} record into a small FWFT FIFO with drop accounting.
module tfsm_xst_logger
  import tfsm_xst_logger_pkg::*;
#(
  parameter int               STMSB = TFSM_STMSB,
  parameter logic [STMSB:0]   ST0   = '0,
  parameter int               SYNC  = 2,
  parameter int               TSW   = TFSM_TSW,
  parameter int               DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       xst,
  input  logic [STMSB:0]             cst,
  input  logic                       clr,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [STMSB:0]             o_from,
  output logic [STMSB:0]             o_to,
  output logic [TSW-1:0]             o_ts,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int RW = rec_width(STMSB, TSW);
  localparam int SW = STMSB + 1;

  logic              xst_s;
  logic [STMSB:0]    cst_s;

  generate
    if (SYNC == 0) begin : g_nosync
      assign xst_s = xst;
      assign cst_s = cst;
    end else begin : g_sync
      logic [SYNC-1:0] xst_q;
      logic [STMSB:0]  cst_q [SYNC];

      // Synchronizer chains; xst and cst move through identical stages.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          xst_q <= '0;
          for (int i = 0; i < SYNC; i++) begin
            cst_q[i] <= ST0;
          end
        end else begin
          xst_q[0] <= xst;
          cst_q[0] <= cst;
          for (int i = 1; i < SYNC; i++) begin
            xst_q[i] <= xst_q[i-1];
            cst_q[i] <= cst_q[i-1];
          end
        end
      end

      assign xst_s = xst_q[SYNC-1];
      assign cst_s = cst_q[SYNC-1];
    end
  endgenerate

  logic [STMSB:0]      last_st_q, last_st_d;
  logic [TSW-1:0]      ts_q, ts_d;
  logic                ovf_q, ovf_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                ev_s;
  logic                pop_s;
  logic                full_s;
  logic                empty_s;
  logic                drop_s;
  logic [RW-1:0]       wrec_s;
  logic [RW-1:0]       rrec_s;

  // Intermediate values seen while xst_s is high never produce an event.
  assign ev_s   = !xst_s && (cst_s != last_st_q);
  assign pop_s  = o_valid && o_ready;
  assign drop_s = ev_s && full_s && !pop_s;
  assign wrec_s = {last_st_q, cst_s, ts_q};

  // Next-state for last state, timestamp and overflow accounting.
  always_comb begin
    last_st_d = last_st_q;
    ts_d      = ts_q + {{(TSW-1){1'b0}}, 1'b1};
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    if (ev_s) begin
      last_st_d = cst_s;
    end else begin
      last_st_d = last_st_q;
    end
    // clr wins over an old drop but a drop in the same cycle still counts.
    if (clr) begin
      ovf_d  = drop_s;
      drop_d = drop_s ? 8'd1 : 8'd0;
    end else if (drop_s) begin
      ovf_d  = 1'b1;
      drop_d = sat_inc(drop_q);
    end else begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
    end
  end

  // Logger state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_st_q <= ST0;
      ts_q      <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      last_st_q <= last_st_d;
      ts_q      <= ts_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  tfsm_fifo_fwft #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (ev_s),
    .pop_i   (pop_s),
    .wdata_i (wrec_s),
    .rdata_o (rrec_s),
    .level_o (level),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign o_valid  = !empty_s;
  assign o_from   = rrec_s[RW-1 -: SW];
  assign o_to     = rrec_s[TSW +: SW];
  assign o_ts     = rrec_s[TSW-1:0];
  assign ovf      = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_tfsm_xst_logger.sv
// Self-checking bench for tfsm_xst_logger: directed scenarios plus random
// stimulus against a queue-based behavioural model.
module tb_tfsm_xst_logger;

  localparam int SYNC  = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        xst = 1'b0;
  logic [3:0]  cst = 4'd0;
  logic        clr = 1'b0;
  logic        o_ready = 1'b0;

  logic        v, v4;
  logic [3:0]  from, to, from4, to4;
  logic [15:0] ts;
  logic [3:0]  ts4;
  logic [2:0]  level, level4;
  logic        ovf, ovf4;
  logic [7:0]  dcnt, dcnt4;

  tfsm_xst_logger #(.SYNC(SYNC), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rstn(rstn), .xst(xst), .cst(cst), .clr(clr),
    .o_valid(v), .o_ready(o_ready), .o_from(from), .o_to(to), .o_ts(ts),
    .level(level), .ovf(ovf), .drop_cnt(dcnt)
  );

  tfsm_xst_logger #(.SYNC(SYNC), .DEPTH(DEPTH), .TSW(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .xst(xst), .cst(cst), .clr(clr),
    .o_valid(v4), .o_ready(o_ready), .o_from(from4), .o_to(to4), .o_ts(ts4),
    .level(level4), .ovf(ovf4), .drop_cnt(dcnt4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  f;
    logic [3:0]  t;
    logic [15:0] ts;
  } rec_t;

  rec_t       mq[$];
  logic [3:0] m_last;
  int         m_ts;
  bit         m_ovf;
  int         m_drop;
  bit         hx[$];
  logic [3:0] hc[$];

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    mq.delete();
    hx.delete();
    hc.delete();
    for (int i = 0; i < SYNC; i++) begin
      hx.push_back(1'b0);
      hc.push_back(4'd0);
    end
    m_last = 4'd0;
    m_ts   = 0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // Advance one clock edge, update the model with the inputs seen at that edge.
  task automatic tick();
    bit         xs, ev, pop, drop;
    logic [3:0] cs;
    rec_t       r;
    @(posedge clk);
    if (rstn) begin
      if (SYNC == 0) begin
        xs = xst;
        cs = cst;
      end else begin
        xs = hx[0];
        cs = hc[0];
        hx.push_back(xst);
        hc.push_back(cst);
        void'(hx.pop_front());
        void'(hc.pop_front());
      end
      ev   = !xs && (cs != m_last);
      pop  = (mq.size() != 0) && o_ready;
      drop = ev && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (ev) begin
        r.f  = m_last;
        r.t  = cs;
        r.ts = 16'(m_ts);
        if (!drop) mq.push_back(r);
        m_last = cs;
      end
      if (clr) begin
        m_ovf  = drop;
        m_drop = drop ? 1 : 0;
      end else if (drop) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      m_ts = (m_ts + 1) % 65536;
    end
    #1;
  endtask

  task automatic do_reset();
    cst  = 4'd0;
    xst  = 1'b0;
    clr  = 1'b0;
    rstn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (v !== 1'b0 || level !== 3'd0 || v4 !== 1'b0 || level4 !== 3'd0) begin
      errors++;
      $display("FAIL reset_async: valid=%0b/%0b level=%0d/%0d, required 0/0 0/0", v, v4, level, level4);
    end
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (v !== 1'b0 || level !== 3'd0 || ovf !== 1'b0 || dcnt !== 8'd0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: valid=%0b level=%0d ovf=%0b drop=%0d, required 0 0 0 0", i, v, level, ovf, dcnt);
      end
    end
  endtask

  task automatic test_latency();
    int n = 0;
    o_ready = 1'b1;
    while (m_ts != 98 && n < 300) begin
      tick();
      n++;
    end
    cst = 4'd5;
    tick();
    checks++;
    if (v !== 1'b0) begin errors++; $display("FAIL latency_k: valid=%0b required 0", v); end
    tick();
    checks++;
    if (v !== 1'b0) begin errors++; $display("FAIL latency_k1: valid=%0b required 0", v); end
    tick();
    checks++;
    if (v !== 1'b1 || from !== 4'd0 || to !== 4'd5 || ts !== 16'd100) begin
      errors++;
      $display("FAIL latency_k2: valid=%0b from=%0d to=%0d ts=%0d, required 1 0 5 100", v, from, to, ts);
    end
    tick();
    checks++;
    if (v !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL latency_drain: valid=%0b level=%0d, required 0 0", v, level);
    end
  endtask

  task automatic test_xst_hold();
    int  n = 0;
    bit  seen = 1'b0;
    o_ready = 1'b1;
    xst = 1'b1;
    cst = 4'd3;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) cst = 4'd7;
      tick();
      checks++;
      if (v !== 1'b0) begin errors++; $display("FAIL xst_hold cyc%0d: valid=%0b required 0", i, v); end
    end
    xst = 1'b0;
    while (!seen && n < 8) begin
      tick();
      n++;
      seen = v;
    end
    checks++;
    if (!seen || from !== 4'd5 || to !== 4'd7) begin
      errors++;
      $display("FAIL xst_settle: valid=%0b from=%0d to=%0d, required 1 5 7", seen, from, to);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (v !== 1'b0) begin errors++; $display("FAIL xst_single cyc%0d: valid=%0b required 0", i, v); end
    end
  endtask

  task automatic test_overflow();
    o_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cst = 4'(i);
      tick();
      tick();
    end
    repeat (3) tick();
    checks++;
    if (level !== 3'd4 || ovf !== 1'b1 || dcnt !== 8'd2) begin
      errors++;
      $display("FAIL ovf_state: level=%0d ovf=%0b drop=%0d, required 4 1 2", level, ovf, dcnt);
    end
    tick();
    checks++;
    if (v !== 1'b1 || from !== mq[0].f || to !== mq[0].t || ts !== mq[0].ts) begin
      errors++;
      $display("FAIL ovf_hold: from=%0d to=%0d ts=%0d, required %0d %0d %0d", from, to, ts, mq[0].f, mq[0].t, mq[0].ts);
    end
    o_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (v !== 1'b1 || to !== 4'(i)) begin
        errors++;
        $display("FAIL ovf_drain%0d: valid=%0b to=%0d, required 1 %0d", i, v, to, i);
      end
      tick();
    end
    o_ready = 1'b0;
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL ovf_empty: level=%0d required 0", level); end
    cst = 4'd7;
    repeat (3) tick();
    checks++;
    if (v !== 1'b1 || from !== 4'd6 || to !== 4'd7) begin
      errors++;
      $display("FAIL ovf_last_st: valid=%0b from=%0d to=%0d, required 1 6 7", v, from, to);
    end
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
  endtask

  task automatic test_full_pushpop();
    o_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 8; i <= 11; i++) begin
      cst = 4'(i);
      tick();
      tick();
    end
    repeat (3) tick();
    cst = 4'd12;
    tick();
    tick();
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    checks++;
    if (level !== 3'd4 || ovf !== 1'b0 || dcnt !== 8'd0 || to !== 4'd9) begin
      errors++;
      $display("FAIL full_pushpop: level=%0d ovf=%0b drop=%0d head_to=%0d, required 4 0 0 9", level, ovf, dcnt, to);
    end
    cst = 4'd13;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (ovf !== 1'b1 || dcnt !== 8'd1 || level !== 3'd4) begin
      errors++;
      $display("FAIL clr_with_drop: ovf=%0b drop=%0d level=%0d, required 1 1 4", ovf, dcnt, level);
    end
    o_ready = 1'b1;
    repeat (4) tick();
    o_ready = 1'b0;
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL full_drain: level=%0d required 0", level); end
  endtask

  task automatic test_wrap_and_reset();
    int n = 0;
    o_ready = 1'b0;
    while ((m_ts % 16) != 13 && n < 40) begin
      tick();
      n++;
    end
    cst = 4'd14;
    tick();
    cst = 4'd15;
    repeat (3) tick();
    checks++;
    if (level4 !== 3'd2 || ts4 !== 4'd15 || to4 !== 4'd14 || ts[3:0] !== 4'd15) begin
      errors++;
      $display("FAIL wrap_first: level=%0d ts4=%0d to=%0d ts16=%0d, required 2 15 14 low-nibble 15", level4, ts4, to4, ts);
    end
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    checks++;
    if (v4 !== 1'b1 || ts4 !== 4'd0 || to4 !== 4'd15 || from4 !== 4'd14) begin
      errors++;
      $display("FAIL wrap_second: valid=%0b ts4=%0d from=%0d to=%0d, required 1 0 14 15", v4, ts4, from4, to4);
    end
    cst = 4'd1;
    repeat (3) tick();
    checks++;
    if (level !== 3'd2) begin errors++; $display("FAIL pre_reset_level: level=%0d required 2", level); end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (v !== 1'b0 || v4 !== 1'b0 || level !== 3'd0) begin
        errors++;
        $display("FAIL post_reset cyc%0d: valid=%0b/%0b level=%0d, required 0 0 0", i, v, v4, level);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      cst     = 4'($urandom_range(0, 3));
      xst     = ($urandom_range(0, 3) == 0);
      o_ready = (i % 200 < 100) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      clr     = ($urandom_range(0, 29) == 0);
      tick();
      checks++;
      if (v !== (mq.size() != 0) || level !== 3'(mq.size()) || ovf !== m_ovf || dcnt !== 8'(m_drop)) begin
        errors++;
        $display("FAIL rand_ctl cyc%0d: valid=%0b level=%0d ovf=%0b drop=%0d, required %0b %0d %0b %0d",
                 i, v, level, ovf, dcnt, mq.size() != 0, mq.size(), m_ovf, m_drop);
      end
      checks++;
      if (v4 !== v || level4 !== 3'(mq.size()) || ovf4 !== m_ovf || dcnt4 !== 8'(m_drop)) begin
        errors++;
        $display("FAIL rand_ctl4 cyc%0d: valid=%0b level=%0d ovf=%0b drop=%0d, required %0b %0d %0b %0d",
                 i, v4, level4, ovf4, dcnt4, mq.size() != 0, mq.size(), m_ovf, m_drop);
      end
      if (mq.size() != 0) begin
        checks++;
        if (from !== mq[0].f || to !== mq[0].t || ts !== mq[0].ts ||
            from4 !== mq[0].f || to4 !== mq[0].t || ts4 !== mq[0].ts[3:0]) begin
          errors++;
          $display("FAIL rand_head cyc%0d: from=%0d to=%0d ts=%0d ts4=%0d, required %0d %0d %0d %0d",
                   i, from, to, ts, ts4, mq[0].f, mq[0].t, mq[0].ts, mq[0].ts[3:0]);
        end
      end
    end
    xst = 1'b0;
    clr = 1'b0;
    o_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_xst_hold();
    test_overflow();
    test_full_pushpop();
    test_wrap_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
